// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, widths, read-back FSM states.
// Used by the display encoder and by the seg7_readback monitor.
package seg7_pkg;

  localparam int DIGITS = 6;
  localparam int SEG_W  = 7;
  localparam int NIB_W  = 4;
  localparam int VAL_W  = DIGITS * NIB_W;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value
  localparam logic [SEG_W-1:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // x^24+x^23+x^22+x^17+1 feedback taps on bits 23,22,21,16
  localparam logic [VAL_W-1:0] SEG7_MISR_TAPS = 24'hE10000;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rb_state_e;

  function automatic logic [SEG_W-1:0] seg7_encode(
    input logic [NIB_W-1:0] n
  );
    return SEG7_GLYPH[n];
  endfunction

endpackage

// File: rtl/seg7_readback_if.sv
// Single-entry valid/ready output bundle of the read-back monitor.
// master = monitor side, slave = consumer side.
interface seg7_readback_if
  import seg7_pkg::*;
  ();

  logic              valid;
  logic              ready;
  logic [VAL_W-1:0]  value;
  logic [DIGITS-1:0] digit_err;
  logic              err;

  modport master (
    output valid,
    output value,
    output digit_err,
    output err,
    input  ready
  );

  modport slave (
    input  valid,
    input  value,
    input  digit_err,
    input  err,
    output ready
  );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Inverse of the glyph table: 7-bit pattern -> nibble.
// Unknown patterns give nibble 0 with err set.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [NIB_W-1:0] nibble_o,
  output logic             err_o
);

  // Reverse lookup; glyphs are unique so at most one hit
  always_comb begin
    nibble_o = '0;
    err_o    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG7_GLYPH[i]) begin
        nibble_o = NIB_W'(i);
        err_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_readback.sv
// Seven-segment read-back monitor: stability filter, glyph decode, 1-entry output.
// Optional signature register enabled by defining SEG7_RB_MISR_EN.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [DIGITS*SEG_W-1:0] segments_i,
  seg7_readback_if.master         out_if,
  output logic                    stable_o,
  output logic                    overrun_o
`ifdef SEG7_RB_MISR_EN
  ,
  output logic [VAL_W-1:0]        misr_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  logic [DIGITS*SEG_W-1:0] seg_q;
  logic [CNT_W-1:0]        cnt;
  logic                    match;
  logic                    capture;

  rb_state_e state;
  rb_state_e state_nxt;

  logic load;
  logic drop;
  logic accept;

  logic [VAL_W-1:0]  dec_value;
  logic [DIGITS-1:0] dec_err;
  logic [VAL_W-1:0]  value_q;
  logic [DIGITS-1:0] err_q;

  assign match    = (segments_i == seg_q);
  assign capture  = en_i & match & (cnt == CNT_CAP);
  assign stable_o = (cnt == CNT_MAX);

  // Sample the bus every cycle, enable or not
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) seg_q <= '0;
    else       seg_q <= segments_i;
  end

  // Count matching samples; saturate so one stable period captures once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (!en_i || !match) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dec
    seg7_glyph_decode u_dec (
      .pattern_i (segments_i[d*SEG_W +: SEG_W]),
      .nibble_o  (dec_value[d*NIB_W +: NIB_W]),
      .err_o     (dec_err[d])
    );
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (capture) state_nxt = HOLD;
      HOLD: if (out_if.ready && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: hand-off strobes and valid
  always_comb begin
    load         = 1'b0;
    drop         = 1'b0;
    accept       = 1'b0;
    out_if.valid = 1'b0;
    unique case (state)
      IDLE: load = capture;
      HOLD: begin
        out_if.valid = 1'b1;
        accept       = out_if.ready;
        load         = capture & out_if.ready;
        drop         = capture & ~out_if.ready;
      end
      default: ;
    endcase
  end

  // Output word; held untouched while waiting for the consumer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      err_q   <= '0;
    end else if (load) begin
      value_q <= dec_value;
      err_q   <= dec_err;
    end
  end

  // Sticky flag for a word lost to a full buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     overrun_o <= 1'b0;
    else if (drop) overrun_o <= 1'b1;
  end

  assign out_if.value     = value_q;
  assign out_if.digit_err = err_q;
  assign out_if.err       = |err_q;

`ifdef SEG7_RB_MISR_EN
  logic [VAL_W-1:0] misr_q;

  // Signature over accepted words only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misr_q <= '0;
    end else if (accept) begin
      misr_q <= {misr_q[VAL_W-2:0], ^(misr_q & SEG7_MISR_TAPS)}
              ^ value_q;
    end
  end

  assign misr_o = misr_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback (STABLE_CYCLES=4).
// Covers reset, latency, glitch restart, illegal glyph, overrun, enable gating.
module tb_seg7_readback;

  logic        clk;
  logic        rst;
  logic        en;
  logic [41:0] seg;
  int          checks;
  int          failures;

`ifdef SEG7_RB_MISR_EN
  logic [23:0] misr;
`endif

  logic        stable;
  logic        overrun;

  logic [6:0] gl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_readback_if rb ();

  seg7_readback #(.STABLE_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .segments_i (seg),
    .out_if     (rb),
    .stable_o   (stable),
    .overrun_o  (overrun)
`ifdef SEG7_RB_MISR_EN
    ,
    .misr_o     (misr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] enc(input logic [23:0] v);
    logic [41:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) r[d*7 +: 7] = gl[v[d*4 +: 4]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [41:0] p;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    rb.ready = 1'b0;
    seg      = '1;
    tick();
    tick();
    chk("rst_valid", 32'(rb.valid), 32'd0);
    chk("rst_value", 32'(rb.value), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);
    chk("rst_err", 32'(rb.err), 32'd0);
    rst = 1'b0;
    tick();

    // latency and single-cycle valid
    en       = 1'b1;
    rb.ready = 1'b1;
    seg      = enc(24'h123456);
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("lat_valid_low", 32'(rb.valid), 32'd0);
    end
    chk("lat_stable_low", 32'(stable), 32'd0);
    tick();
    chk("lat_valid", 32'(rb.valid), 32'd1);
    chk("lat_value", 32'(rb.value), 32'h123456);
    chk("lat_err", 32'(rb.err), 32'd0);
    chk("lat_stable", 32'(stable), 32'd1);
    tick();
    chk("one_cycle", 32'(rb.valid), 32'd0);
    tick();
    tick();
    tick();
    chk("no_recapture", 32'(rb.valid), 32'd0);

    // glitch on digit 2 restarts the counter
    seg = enc(24'hABCDEF);
    tick();
    tick();
    p = enc(24'hABCDEF);
    p[14 +: 7] = p[14 +: 7] ^ 7'b0000001;
    seg = p;
    tick();
    chk("glitch_valid", 32'(rb.valid), 32'd0);
    seg = enc(24'hABCDEF);
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("glitch_wait", 32'(rb.valid), 32'd0);
    end
    tick();
    chk("glitch_cap", 32'(rb.valid), 32'd1);
    chk("glitch_value", 32'(rb.value), 32'hABCDEF);
    tick();

    // illegal glyph on digit 3
    p = enc(24'h000000);
    p[21 +: 7] = 7'b1111111;
    seg = p;
    repeat (5) tick();
    chk("bad_valid", 32'(rb.valid), 32'd1);
    chk("bad_value", 32'(rb.value), 32'h000000);
    chk("bad_digit_err", 32'(rb.digit_err), 32'h08);
    chk("bad_err", 32'(rb.err), 32'd1);
    tick();

    // overrun while consumer stalls
    rb.ready = 1'b0;
    seg = enc(24'h000111);
    repeat (5) tick();
    chk("ovr_first", 32'(rb.value), 32'h000111);
    seg = enc(24'h000222);
    repeat (4) tick();
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    tick();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_hold", 32'(rb.value), 32'h000111);
    chk("ovr_valid", 32'(rb.valid), 32'd1);
    seg = enc(24'h000333);
    repeat (4) tick();
    rb.ready = 1'b1;
    tick();
    chk("ovr_reload", 32'(rb.value), 32'h000333);
    chk("ovr_valid_kept", 32'(rb.valid), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    tick();
    chk("ovr_accepted", 32'(rb.valid), 32'd0);

    // async reset in HOLD
    rb.ready = 1'b0;
    seg = enc(24'h000444);
    repeat (5) tick();
    chk("arst_pre", 32'(rb.valid), 32'd1);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("arst_valid", 32'(rb.valid), 32'd0);
    chk("arst_value", 32'(rb.value), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_stable", 32'(stable), 32'd0);
    tick();
    rst = 1'b0;

    // disabled monitor never captures
    for (int e = 0; e < 4; e++) begin
      seg = enc(24'(e * 24'h111111));
      tick();
    end
    repeat (6) tick();
    chk("dis_valid", 32'(rb.valid), 32'd0);
    chk("dis_stable", 32'(stable), 32'd0);

`ifdef SEG7_RB_MISR_EN
    en       = 1'b1;
    rb.ready = 1'b1;
    seg = enc(24'h000001);
    repeat (5) tick();
    chk("misr_seed", 32'(misr), 32'd0);
    tick();
    chk("misr_1", 32'(misr), 32'h000001);
    seg = enc(24'h000002);
    repeat (6) tick();
    chk("misr_2", 32'(misr), 32'h000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
